// File: rtl/axil_uart_tx.sv
// AXI-Lite console peripheral: 16-byte register window, TX FIFO, 8N1 serializer.
// Valid/ready: a beat transfers on the rising edge where valid and ready are both high; valid holds until then.
module axil_uart_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  txd,
  output logic                  tx_idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          state;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     div_reg, div_lat, div_next, bit_cnt;
  logic            enable;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            aw_fire, ar_fire, fifo_full, fifo_empty, push, pop, tx_write;
  logic [31:0]     status_word;

  assign aw_fire    = s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
  assign ar_fire    = s_axil_arvalid && !s_axil_rvalid;
  assign s_axil_awready = aw_fire;
  assign s_axil_wready  = aw_fire;
  assign s_axil_arready = ar_fire;
  assign s_axil_rresp   = 2'b00;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign tx_write   = aw_fire && (s_axil_awaddr[3:2] == 2'd0) && s_axil_wstrb[0];
  assign push       = tx_write && !fifo_full;
  assign pop        = (state == ST_IDLE) && enable && !fifo_empty;
  assign tx_idle    = (state == ST_IDLE) && fifo_empty;

  assign status_word = {16'h0, 8'(count), 5'b0, fifo_empty, fifo_full, state != ST_IDLE};

  // Byte-strobe merge; zero would stall the bit counter, so it becomes 1.
  always_comb begin
    div_next = div_reg;
    if (s_axil_wstrb[0]) div_next[7:0]  = s_axil_wdata[7:0];
    if (s_axil_wstrb[1]) div_next[15:8] = s_axil_wdata[15:8];
    if (div_next == 16'd0) div_next = 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_axil_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      div_reg       <= 16'(CLK_DIV);
      enable        <= 1'b1;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
      if (aw_fire) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= (tx_write && fifo_full) ? 2'b10 : 2'b00;
        case (s_axil_awaddr[3:2])
          2'd2:    div_reg <= div_next;
          2'd3:    if (s_axil_wstrb[0]) enable <= s_axil_wdata[0];
          default: ;
        endcase
      end

      if (s_axil_rvalid && s_axil_rready) s_axil_rvalid <= 1'b0;
      if (ar_fire) begin
        s_axil_rvalid <= 1'b1;
        case (s_axil_araddr[3:2])
          2'd1:    s_axil_rdata <= status_word;
          2'd2:    s_axil_rdata <= {16'h0, div_reg};
          2'd3:    s_axil_rdata <= {31'h0, enable};
          default: s_axil_rdata <= '0;
        endcase
      end
    end
  end

  // Serializer: each bit holds for div_lat clocks, counted div_lat-1 down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      txd     <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div_lat <= 16'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_START;
            txd     <= 1'b0;
            shreg   <= fifo_mem[rd_ptr];
            div_lat <= div_reg;
            bit_cnt <= div_reg - 16'd1;
          end
        end
        ST_START: begin
          if (bit_cnt == 16'd0) begin
            state   <= ST_DATA;
            txd     <= shreg[0];
            bit_idx <= 3'd0;
            bit_cnt <= div_lat - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == 16'd0) begin
            bit_cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_cnt == 16'd0) state <= ST_IDLE;
          else bit_cnt <= bit_cnt - 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wdata[DATA_WIDTH-1:16],
                       s_axil_wstrb[STRB_WIDTH-1:2], s_axil_awaddr[1:0], s_axil_araddr[1:0]};

endmodule
